// File: rtl/paced_digit_counter.sv
// ---------------------------------------------------------------------------
// paced_digit_counter
//
// Multi-digit up/down counter advanced by an internal rate prescaler tick.
// There is no derived clock: everything runs on clk, and the count moves only
// on the cycle where the prescaler reaches its terminal value.
// Each digit drives an active-low 7-segment pattern.
//
// Optional feature: define PACED_COUNTER_BCD_EN to compile in decimal (BCD)
// counting, BCD wrap and load clamping. The bcd input then selects the mode.
// Without the macro the bcd input is ignored and counting is plain binary.
//
// Ports:
//   clk       - single clock, all logic on posedge
//   reset     - asynchronous, active-high reset
//   en        - count enable; low freezes the prescaler and the count
//   clr       - synchronous clear (count, prescaler, tc)
//   ld        - synchronous load of load_val
//   load_val  - value loaded on ld, 4*DIGITS bits
//   up        - 1 = count up, 0 = count down
//   bcd       - 1 = decimal digits (only with PACED_COUNTER_BCD_EN)
//   rate      - selects prescaler terminal RATE0..RATE3
//   count     - registered count value
//   tick      - registered one-cycle prescaler pulse
//   tc        - registered one-cycle flag on the step that wraps the count
//   hex       - active-low segments, digit i at [7i+6:7i], bit0=a .. bit6=g
// ---------------------------------------------------------------------------
module paced_digit_counter #(
   parameter int          DIGITS = 2,
   parameter int          DIV_W  = 28,
   parameter int unsigned RATE0  = 0,
   parameter int unsigned RATE1  = 49999999,
   parameter int unsigned RATE2  = 99999999,
   parameter int unsigned RATE3  = 199999999
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  en,
   input  logic                  clr,
   input  logic                  ld,
   input  logic [4*DIGITS-1:0]   load_val,
   input  logic                  up,
   input  logic                  bcd,
   input  logic [1:0]            rate,
   output logic [4*DIGITS-1:0]   count,
   output logic                  tick,
   output logic                  tc,
   output logic [7*DIGITS-1:0]   hex
);

   localparam int W = 4 * DIGITS;

   // Active-low segment pattern for one hex digit (gfedcba).
   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'h0: seg7 = 7'b1000000;
         4'h1: seg7 = 7'b1111001;
         4'h2: seg7 = 7'b0100100;
         4'h3: seg7 = 7'b0110000;
         4'h4: seg7 = 7'b0011001;
         4'h5: seg7 = 7'b0010010;
         4'h6: seg7 = 7'b0000010;
         4'h7: seg7 = 7'b1111000;
         4'h8: seg7 = 7'b0000000;
         4'h9: seg7 = 7'b0010000;
         4'hA: seg7 = 7'b0001000;
         4'hB: seg7 = 7'b0000011;
         4'hC: seg7 = 7'b1000110;
         4'hD: seg7 = 7'b0100001;
         4'hE: seg7 = 7'b0000110;
         default: seg7 = 7'b0001110;
      endcase
   endfunction

   // ------------------------------------------------------------------------
   // Prescaler
   // ------------------------------------------------------------------------
   logic [DIV_W-1:0] pcnt;
   logic [DIV_W-1:0] term;
   logic [1:0]       rate_q;
   logic             rate_chg;
   logic             terminal;

   always_comb begin
      case (rate)
         2'd0:    term = DIV_W'(RATE0);
         2'd1:    term = DIV_W'(RATE1);
         2'd2:    term = DIV_W'(RATE2);
         default: term = DIV_W'(RATE3);
      endcase
   end

   // A rate change restarts the period, so the cycle that sees the change
   // never ticks even if pcnt happens to equal the new terminal value.
   assign rate_chg = (rate != rate_q);
   assign terminal = !rate_chg && en && (pcnt == term);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pcnt   <= '0;
         rate_q <= 2'd0;
         tick   <= 1'b0;
      end else begin
         rate_q <= rate;
         tick   <= terminal;
         if (clr || rate_chg || terminal)
            pcnt <= '0;
         else if (en)
            pcnt <= pcnt + 1'b1;
      end
   end

   // ------------------------------------------------------------------------
   // Next count on a step, and whether that step wraps the full count
   // ------------------------------------------------------------------------
   logic [W-1:0] stepped;
   logic         wrap;
   logic [W-1:0] load_eff;

`ifdef PACED_COUNTER_BCD_EN
   logic       carry;
   logic [3:0] dig;

   // NOTE: every combinational output gets a default before any branch so
   // no path leaves it unassigned (which would infer a latch).
   always_comb begin
      stepped = up ? count + 1'b1 : count - 1'b1;
      wrap    = up ? &count : ~|count;
      carry   = 1'b1;
      dig     = 4'h0;
      if (bcd) begin
         // Ripple through the digits; carry out of the top digit is the wrap.
         for (int i = 0; i < DIGITS; i++) begin
            dig = count[4*i +: 4];
            if (carry) begin
               if (up) begin
                  // >= 9 also folds any stray non-decimal nibble back to 0.
                  if (dig >= 4'd9) dig = 4'd0;
                  else begin
                     dig   = dig + 4'd1;
                     carry = 1'b0;
                  end
               end else begin
                  if (dig == 4'd0) dig = 4'd9;
                  else begin
                     dig   = dig - 4'd1;
                     carry = 1'b0;
                  end
               end
            end
            stepped[4*i +: 4] = dig;
         end
         wrap = carry;
      end
   end

   always_comb begin
      load_eff = load_val;
      if (bcd) begin
         for (int i = 0; i < DIGITS; i++)
            if (load_val[4*i +: 4] > 4'd9) load_eff[4*i +: 4] = 4'd9;
      end
   end
`else
   logic unused_bcd;
   assign unused_bcd = bcd;

   always_comb begin
      stepped = up ? count + 1'b1 : count - 1'b1;
      wrap    = up ? &count : ~|count;
   end

   assign load_eff = load_val;
`endif

   // ------------------------------------------------------------------------
   // Count register: clr > ld > step > hold
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
         tc    <= 1'b0;
      end else if (clr) begin
         count <= '0;
         tc    <= 1'b0;
      end else if (ld) begin
         count <= load_eff;
         tc    <= 1'b0;
      end else if (terminal) begin
         count <= stepped;
         tc    <= wrap;
      end else begin
         tc    <= 1'b0;
      end
   end

   // ------------------------------------------------------------------------
   // Segment decode, combinational from count
   // ------------------------------------------------------------------------
   for (genvar g = 0; g < DIGITS; g++) begin : g_seg
      assign hex[7*g +: 7] = seg7(count[4*g +: 4]);
   end

endmodule

// File: tb/tb_paced_digit_counter.sv
// ---------------------------------------------------------------------------
// tb_paced_digit_counter
//
// Directed bench for paced_digit_counter with DIGITS=2, RATE0=0, RATE1=3,
// RATE2=5, RATE3=7. Inputs change and outputs are sampled 1 time unit after
// each rising edge. Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_paced_digit_counter;

   logic        clk = 1'b0;
   logic        reset;
   logic        en, clr, ld, up, bcd;
   logic [7:0]  load_val;
   logic [1:0]  rate;
   logic [7:0]  count;
   logic        tick, tc;
   logic [13:0] hex;

   int n_total = 0;
   int n_pass  = 0;

   paced_digit_counter #(
      .DIGITS (2),
      .DIV_W  (28),
      .RATE0  (0),
      .RATE1  (3),
      .RATE2  (5),
      .RATE3  (7)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .en       (en),
      .clr      (clr),
      .ld       (ld),
      .load_val (load_val),
      .up       (up),
      .bcd      (bcd),
      .rate     (rate),
      .count    (count),
      .tick     (tick),
      .tc       (tc),
      .hex      (hex)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b0; en = 1'b0; clr = 1'b0; ld = 1'b0; up = 1'b1; bcd = 1'b0;
      load_val = 8'h00; rate = 2'd0;

      // Reset state, checked before any clock edge.
      #2 reset = 1'b1;
      #1;
      check("rst_count", count, 8'h00);
      check("rst_tick",  tick,  1'b0);
      check("rst_tc",    tc,    1'b0);
      check("rst_hex",   hex,   14'h2040);
      @(negedge clk) reset = 1'b0;

      // Hex wrap up and down, rate 0 (tick every cycle).
      ld = 1'b1; load_val = 8'hFE; up = 1'b1;
      step();
      check("ld_fe", count, 8'hFE);
      ld = 1'b0; en = 1'b1;
      step();
      check("up_ff",      count, 8'hFF);
      check("up_ff_tick", tick,  1'b1);
      check("up_ff_tc",   tc,    1'b0);
      step();
      check("up_wrap",    count, 8'h00);
      check("up_wrap_tc", tc,    1'b1);
      check("hex_00",     hex,   14'h2040);
      step();
      check("up_01",      count, 8'h01);
      check("up_01_tc",   tc,    1'b0);
      check("hex_01",     hex,   14'h2079);
      up = 1'b0;
      step();
      check("dn_00",      count, 8'h00);
      check("dn_00_tc",   tc,    1'b0);
      step();
      check("dn_wrap",    count, 8'hFF);
      check("dn_wrap_tc", tc,    1'b1);
      check("hex_ff",     hex,   14'h070E);

      // Prescaler: rate 1 (F=3) after a rate change -> first tick 5 edges on.
      en = 1'b0; ld = 1'b1; load_val = 8'h00; up = 1'b1;
      step();
      ld = 1'b0; rate = 2'd1; en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         check("r1_first_gap", tick, 1'b0);
      end
      step();
      check("r1_tick1",  tick,  1'b1);
      check("r1_count1", count, 8'h01);
      for (int i = 0; i < 3; i++) begin
         step();
         check("r1_gap", tick, 1'b0);
      end
      step();
      check("r1_tick2",  tick,  1'b1);
      check("r1_count2", count, 8'h02);
      step();
      check("r1_mid", tick, 1'b0);

      // Switch to rate 2 (F=5) mid-period: next tick 7 cycles later.
      rate = 2'd2;
      for (int i = 0; i < 6; i++) begin
         step();
         check("r2_first_gap", tick, 1'b0);
      end
      step();
      check("r2_tick1",  tick,  1'b1);
      check("r2_count3", count, 8'h03);
      for (int i = 0; i < 5; i++) begin
         step();
         check("r2_gap", tick, 1'b0);
      end
      step();
      check("r2_tick2",  tick,  1'b1);
      check("r2_count4", count, 8'h04);

      // Enable low for 10 cycles: no ticks, count holds.
      en = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         check("en0_tick", tick, 1'b0);
      end
      check("en0_count", count, 8'h04);

      // Priority: load on the tick cycle wins over the step.
      rate = 2'd0; en = 1'b1;
      step();
      check("pr_restart", tick, 1'b0);
      ld = 1'b1; load_val = 8'h42;
      step();
      check("pr_ld_tick",  tick,  1'b1);
      check("pr_ld_count", count, 8'h42);
      check("pr_ld_tc",    tc,    1'b0);
      check("pr_ld_hex",   hex,   14'h0CA4);

      // clr with ld: count clears and the prescaler restarts from 0.
      ld = 1'b0; rate = 2'd1;
      step();
      step();
      step();
      clr = 1'b1; ld = 1'b1;
      step();
      check("pr_clr_count", count, 8'h00);
      check("pr_clr_tc",    tc,    1'b0);
      clr = 1'b0; ld = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         check("pr_clr_gap", tick, 1'b0);
      end
      step();
      check("pr_clr_tick",  tick,  1'b1);
      check("pr_clr_count1", count, 8'h01);

`ifdef PACED_COUNTER_BCD_EN
      // BCD mode.
      bcd = 1'b1; rate = 2'd0; en = 1'b0; ld = 1'b1; load_val = 8'h99;
      step();
      check("bcd_ld99", count, 8'h99);
      ld = 1'b0; en = 1'b1; up = 1'b1;
      step();
      check("bcd_up_wrap",    count, 8'h00);
      check("bcd_up_wrap_tc", tc,    1'b1);
      up = 1'b0;
      step();
      check("bcd_dn_wrap",    count, 8'h99);
      check("bcd_dn_wrap_tc", tc,    1'b1);
      en = 1'b0; ld = 1'b1; load_val = 8'h19;
      step();
      ld = 1'b0; en = 1'b1; up = 1'b1;
      step();
      check("bcd_19_20",    count, 8'h20);
      check("bcd_19_20_tc", tc,    1'b0);
      en = 1'b0; ld = 1'b1; load_val = 8'h3C;
      step();
      check("bcd_clamp", count, 8'h39);
      ld = 1'b0; en = 1'b1;
      step();
      check("bcd_39_40", count, 8'h40);
      bcd = 1'b0; en = 1'b0; ld = 1'b1; load_val = 8'h3C;
      step();
      check("hexmode_noclamp", count, 8'h3C);
      ld = 1'b0;
`else
      // BCD compiled out: bcd input ignored.
      bcd = 1'b1; rate = 2'd0; en = 1'b0; ld = 1'b1; load_val = 8'h09;
      step();
      check("nobcd_ld09", count, 8'h09);
      ld = 1'b0; en = 1'b1; up = 1'b1;
      step();
      check("nobcd_0a",     count, 8'h0A);
      check("nobcd_0a_hex", hex,   14'h2008);
      en = 1'b0; ld = 1'b1; load_val = 8'h3C;
      step();
      check("nobcd_noclamp", count, 8'h3C);
      ld = 1'b0;
`endif

      // Reset mid-run, between edges: acts without a clock edge.
      rate = 2'd0; en = 1'b1; up = 1'b1;
      step();
      step();
      check("run_tick", tick, 1'b1);
      #2 reset = 1'b1;
      #1;
      check("mid_rst_count", count, 8'h00);
      check("mid_rst_tick",  tick,  1'b0);
      check("mid_rst_tc",    tc,    1'b0);
      check("mid_rst_hex",   hex,   14'h2040);
      step();
      check("held_rst_count", count, 8'h00);
      @(negedge clk) reset = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/paced_digit_counter.md
# paced_digit_counter

Parametrised multi-digit counter with a built-in rate prescaler and per-digit 7-segment outputs. It is the next generation of the lab divider-plus-counter pair. It counts on a one-cycle enable tick and does not use a derived clock. It supports up/down counting, synchronous load and clear, and optional BCD counting. It sits between the board clock/switches and the HEX displays.

## Interface
Parameters:
- `DIGITS`, 2: number of 4-bit digits (1–8).
- `DIV_W`, 28: prescaler counter width.
- `RATE0`, 0: prescaler terminal value for `rate`=0. Tick period is RATE0+1 cycles.
- `RATE1`, 49999999: terminal value for `rate`=1 (1 Hz at 50 MHz).
- `RATE2`, 99999999: terminal value for `rate`=2.
- `RATE3`, 199999999: terminal value for `rate`=3.

Ports:
- `clk` in 1: the single clock. All logic is posedge.
- `reset` in 1: asynchronous, active-high reset.
- `en` in 1: count enable. Low freezes the prescaler and the count.
- `clr` in 1: synchronous clear.
- `ld` in 1: synchronous load.
- `load_val` in 4·DIGITS: value loaded on `ld`.
- `up` in 1: 1 = count up, 0 = count down.
- `bcd` in 1: 1 = decimal digits (only with the macro below).
- `rate` in 2: selects RATE0..RATE3.
- `count` out 4·DIGITS: registered count value.
- `tick` out 1: registered one-cycle prescaler pulse.
- `tc` out 1: registered one-cycle wrap flag.
- `hex` out 7·DIGITS: active-low segments. Digit i is at [7i+6:7i]; bit 0 = a … bit 6 = g.

## Operation
- Prescaler `pcnt` (DIV_W bits) uses terminal value F = RATE[`rate`].
- The registered copy `rate_q` is updated every cycle. If `rate` ≠ `rate_q`:
  - `pcnt` ← 0 and no tick occurs that cycle.
- Otherwise, if `en` and `pcnt`==F:
  - `pcnt` ← 0 and `tick` ← 1.
- Otherwise, if `en`:
  - `pcnt` ← `pcnt`+1 and `tick` ← 0.
- `en`=0 holds `pcnt` and forces `tick` ← 0.
- Count update priority, highest first:
  - `clr`: `count` ← 0, `pcnt` ← 0, `tc` ← 0.
  - `ld`: `count` ← `load_val`, `tc` ← 0. The prescaler keeps running.
  - The prescaler terminal condition (the cycle that sets `tick`) with `en`: step the count by ±1.
  - Otherwise: hold the count, `tc` ← 0.
- Hex mode:
  - Plain binary on 4·DIGITS bits.
  - Up from all-F wraps to 0; down from 0 wraps to all-F.
- BCD mode:
  - Per-digit ripple; a digit carries when it wraps 9→0 (up) or 0→9 (down).
  - Up from all-9 wraps to 0; down from 0 wraps to all-9.
  - On load, any nibble >9 is clamped to 9.
  - While counting, nibbles are always ≤9.
- `tc` ← 1 on exactly the step that wraps the full count. It is 0 on all other cycles.
- `hex` is combinational from `count` and shows digits 0–F:
  - 0 = 7'b1000000, 1 = 7'b1111001, … F = 7'b0001110.
- Changing `bcd` while counting takes effect on the next step. The count is not reformatted.

## Timing
- Reset values: `count`=0, `pcnt`=0, `rate_q`=`rate` sampled as 0, `tick`=0, `tc`=0, `hex`= every digit 7'b1000000.
- Reset acts immediately, without a clock edge. Reset mid-count discards all state.
- `count` and `tc` update on the same edge as `tick` rises. Latency from prescaler terminal to new count is 1 cycle.
- With `en` held high and `rate` stable, ticks occur every F+1 cycles. F=0 gives a tick every cycle.
- After a `rate` change, the first tick occurs F+2 cycles later: one cycle for the restart, then F+1.
- `ld` or `clr` in the same cycle as a terminal prescaler: the tick still pulses, but the load or clear wins and the count does not step.
- `hex` follows `count` within the same cycle, with combinational delay only.

## Configuration
- `PACED_COUNTER_BCD_EN` defined:
  - BCD counting, wrap and load clamping are compiled in.
  - `bcd` selects the mode.
- Undefined:
  - The BCD logic is absent and the `bcd` input is ignored.
  - The counter is always plain binary; `load_val` is loaded unclamped.

## Test plan
- Reset: assert `reset` mid-run between clock edges → `count`=0, `tc`=0, `tick`=0 and `hex`=14'h2040 (DIGITS=2) before the next edge.
- Hex wrap: DIGITS=2, `rate`=0, `en`=1, `up`=1, load 8'hFE → next two steps give 8'hFF then 8'h00, with `tc`=1 only on the 8'h00 cycle. With `up`=0 from 8'h00 → 8'hFF with `tc`=1.
- Prescaler: RATE1=3, `rate`=1 → `tick` every 4 cycles and the count increments by 1 per tick. Switch to `rate`=2 (RATE2=5) mid-period → next tick arrives 7 cycles later, then every 6 cycles. `en`=0 for 10 cycles → no ticks and the count holds.
- BCD (macro on, `bcd`=1):
  - Load 8'h99, `up`=1 → 8'h00 with `tc`=1.
  - `up`=0 from 8'h00 → 8'h99 with `tc`=1.
  - 8'h19 up → 8'h20.
  - Load 8'h3C → 8'h39.
- Priority: `ld`=1 (load_val 8'h42) on the tick cycle → `count`=8'h42, `tc`=0. Then `clr`=1 and `ld`=1 together → `count`=0 and `pcnt` restarts.
- Macro off: `bcd`=1, load 8'h09, one step up → 8'h0A.
